mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single memory port of the SAM CPU between the microprogrammed controller's datapath (CPU requester) and an I/O/DMA requester. Arbitrates two-way round-robin, sequences a fixed-latency memory access, returns read data with a one-cycle acknowledge, and drives `cpu_wait` to the controller so its wait branch holds the microsequencer until the CPU access completes.

## Interface
Parameters:
- `AW`, 12, address width
- `DW`, 16, data width
- `MEM_LAT`, 2, memory access cycles (legal range 1–15)

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU access request, held until `cpu_ack`
- `cpu_we`  in  1  CPU write (1) / read (0)
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  CPU read data, valid while `cpu_ack`=1
- `cpu_ack`  out  1  one-cycle completion pulse to CPU
- `cpu_wait`  out  1  CPU must stall: `cpu_req & ~cpu_ack`
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_rdata`, `io_ack`: same as the CPU set, for the I/O requester
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write strobe
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid in the last access cycle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any request is pending, latch the winner's id, `we`, `addr` and `wdata`, load the latency counter with `MEM_LAT-1`, and go to ACCESS. With no request, stay in IDLE.
- Arbitration when both requests are high in IDLE: grant the requester that was not granted last. `last_grant` resets to IO, so the CPU wins the first tie. A lone requester always wins. `last_grant` updates on every grant.
- ACCESS:
  - `mem_en`=1 for all `MEM_LAT` cycles; `mem_addr`/`mem_wdata` come from the latched values.
  - `mem_we`=1 only in the first ACCESS cycle, and only for a write.
  - The counter decrements each cycle. At 0, capture `mem_rdata` into the granted requester's rdata register (reads only) and go to DONE.
- DONE: pulse the granted requester's ack for exactly one cycle, then go to IDLE. The non-granted ack stays 0.
- Read data registers hold their value until the next read for that requester. Write accesses leave rdata unchanged.
- Requester rule: hold `req`/`we`/`addr`/`wdata` stable until ack. A new access may be requested by keeping `req` high after ack; it is re-sampled in IDLE.
- A request withdrawn before ack is a protocol violation. The access still completes and the ack still pulses.
- Requests arriving during ACCESS/DONE wait; they are seen in the next IDLE.
- Reset (any time, including mid-access):
  - State IDLE; `mem_en`, `mem_we`, both acks = 0; `last_grant`=IO; counter = 0.
  - rdata registers = 0, `mem_addr`/`mem_wdata` = 0.
  - An interrupted access is abandoned, with no ack issued.

## Timing
- Request seen high in IDLE at cycle 0 → ACCESS in cycles 1..`MEM_LAT` → ack in cycle `MEM_LAT`+1 → IDLE in cycle `MEM_LAT`+2.
- Request-to-ack latency is `MEM_LAT`+1 cycles. The access period is `MEM_LAT`+2 cycles per transfer, including the IDLE sample cycle.
- `cpu_wait` is combinational from `cpu_req` and registered `cpu_ack`. It is 0 in the ack cycle, so the controller advances on that edge.
- Under continuous contention the requesters strictly alternate.
- `MEM_LAT`=1: a single ACCESS cycle, with `mem_we` and the rdata capture in that same cycle.
- All outputs except `cpu_wait`/`io_wait`-style combinational terms are registered.

## Structure
- Shared package `sam_bus_pkg`:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - Requester ids (REQ_CPU=1'b0, REQ_IO=1'b1)
  - Default `AW`/`DW`
- One sub-module `rr_arb2`: two-input round-robin picker with the registered `last_grant` flag and a grant-enable input.
- The FSM, latency counter and data registers live in the top module.

## Test plan
- Reset mid-ACCESS of a CPU write: all mem outputs and acks go 0 immediately; after release, state is IDLE and no ack occurs.
- CPU read, `addr`=12'h02A, memory returns 16'hBEEF, `MEM_LAT`=2: `mem_en` high for 2 cycles, `mem_we`=0, `cpu_ack` in cycle 3 with `cpu_rdata`=16'hBEEF, `cpu_wait` high in cycles 0–2.
- IO write, `addr`=12'h100, `wdata`=16'h1234: `mem_we` high only in the first ACCESS cycle with matching addr/data; `io_ack` pulses once; `io_rdata` unchanged.
- Both requesters held high from reset release for 4 transfers: grants go CPU, IO, CPU, IO; each ack lasts one cycle; a new transfer starts every `MEM_LAT`+2 cycles.
- CPU keeps `req` high across ack for two reads, 16'h0001 then 16'h0002: two distinct acks with the correct data; the second transfer starts in the IDLE cycle right after the first ack.
- `MEM_LAT`=1, single read: ack in cycle 2; `MEM_LAT`=15: ack in cycle 16 and the counter wraps correctly.

Source files
------------

// File: rtl/sam_bus_pkg.sv
// sam_bus_pkg: shared encodings for the SAM memory bus arbiter.
package sam_bus_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;
    localparam int DEF_AW = 12;
    localparam int DEF_DW = 16;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; a tie goes to the requester not granted last.
module rr_arb2
    import sam_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req_cpu,
    input  logic i_req_io,
    input  logic i_en,
    output logic o_valid,
    output logic o_grant
);
    logic r_last;
    assign o_valid = i_req_cpu | i_req_io;
    assign o_grant = (i_req_cpu & i_req_io) ? ~r_last : i_req_io;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_last <= REQ_IO;
        else if (i_en && o_valid) r_last <= o_grant;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one fixed-latency memory port between the CPU datapath and an I/O requester.
module mem_bus_arbiter
    import sam_bus_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_id, r_we;
    logic       w_valid, w_grant, w_we;
    assign w_we     = w_grant ? io_we : cpu_we;
    assign cpu_wait = cpu_req & ~cpu_ack;
    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req_cpu (cpu_req),
        .i_req_io  (io_req),
        .i_en      (r_state == ST_IDLE),
        .o_valid   (w_valid),
        .o_grant   (w_grant)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_id      <= REQ_CPU;
            r_we      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            io_ack    <= 1'b0;
            cpu_rdata <= '0;
            io_rdata  <= '0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            io_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_valid) begin
                    r_state   <= ST_ACCESS;
                    r_id      <= w_grant;
                    r_we      <= w_we;
                    r_cnt     <= LAT_M1;
                    mem_en    <= 1'b1;
                    mem_we    <= w_we;
                    mem_addr  <= w_grant ? io_addr : cpu_addr;
                    mem_wdata <= w_grant ? io_wdata : cpu_wdata;
                end
                // memory data is valid in the last access cycle, so capture it as we leave ACCESS
                ST_ACCESS: if (r_cnt == 4'd0) begin
                    r_state <= ST_DONE;
                    mem_en  <= 1'b0;
                    cpu_ack <= r_id == REQ_CPU;
                    io_ack  <= r_id == REQ_IO;
                    if (!r_we && r_id == REQ_CPU) cpu_rdata <= mem_rdata;
                    if (!r_we && r_id == REQ_IO) io_rdata <= mem_rdata;
                end else r_cnt <= r_cnt - 4'd1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with per-DUT ack scoreboards for MEM_LAT of 2, 1 and 15.
module tb_mem_bus_arbiter;
    typedef struct {
        logic        id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb2[$];
    exp_t sb1[$];
    exp_t sb15[$];
    exp_t e2, e1, e15;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        d2_cpu_req = 0, d2_cpu_we = 0, d2_io_req = 0, d2_io_we = 0;
    logic [11:0] d2_cpu_addr = 0, d2_io_addr = 0;
    logic [15:0] d2_cpu_wdata = 0, d2_io_wdata = 0;
    logic [15:0] d2_cpu_rdata, d2_io_rdata, d2_mem_wdata, d2_mem_rdata;
    logic        d2_cpu_ack, d2_cpu_wait, d2_io_ack, d2_mem_en, d2_mem_we;
    logic [11:0] d2_mem_addr;

    logic        d1_req = 0, d15_req = 0;
    logic [11:0] d1_addr = 0, d15_addr = 0;
    logic [15:0] d1_rdata, d1_io_rdata, d1_mem_wdata, d15_rdata, d15_io_rdata, d15_mem_wdata;
    logic        d1_ack, d1_wait, d1_io_ack, d1_mem_en, d1_mem_we;
    logic        d15_ack, d15_wait, d15_io_ack, d15_mem_en, d15_mem_we;
    logic [11:0] d1_mem_addr, d15_mem_addr;

    function automatic logic [15:0] rd_model(input logic [11:0] a);
        case (a)
            12'h02A: return 16'hBEEF;
            12'h010: return 16'h0001;
            12'h011: return 16'h0002;
            12'h200: return 16'h1111;
            12'h300: return 16'h2222;
            default: return 16'h0000;
        endcase
    endfunction

    assign d2_mem_rdata = rd_model(d2_mem_addr);

    mem_bus_arbiter #(.AW(12), .DW(16), .MEM_LAT(2)) u_d2 (
        .clk(clk), .reset(reset),
        .cpu_req(d2_cpu_req), .cpu_we(d2_cpu_we), .cpu_addr(d2_cpu_addr), .cpu_wdata(d2_cpu_wdata),
        .cpu_rdata(d2_cpu_rdata), .cpu_ack(d2_cpu_ack), .cpu_wait(d2_cpu_wait),
        .io_req(d2_io_req), .io_we(d2_io_we), .io_addr(d2_io_addr), .io_wdata(d2_io_wdata),
        .io_rdata(d2_io_rdata), .io_ack(d2_io_ack),
        .mem_en(d2_mem_en), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
        .mem_rdata(d2_mem_rdata)
    );

    mem_bus_arbiter #(.AW(12), .DW(16), .MEM_LAT(1)) u_d1 (
        .clk(clk), .reset(reset),
        .cpu_req(d1_req), .cpu_we(1'b0), .cpu_addr(d1_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(d1_rdata), .cpu_ack(d1_ack), .cpu_wait(d1_wait),
        .io_req(1'b0), .io_we(1'b0), .io_addr(12'h000), .io_wdata(16'h0000),
        .io_rdata(d1_io_rdata), .io_ack(d1_io_ack),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata({4'hA, d1_mem_addr})
    );

    mem_bus_arbiter #(.AW(12), .DW(16), .MEM_LAT(15)) u_d15 (
        .clk(clk), .reset(reset),
        .cpu_req(d15_req), .cpu_we(1'b0), .cpu_addr(d15_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(d15_rdata), .cpu_ack(d15_ack), .cpu_wait(d15_wait),
        .io_req(1'b0), .io_we(1'b0), .io_addr(12'h000), .io_wdata(16'h0000),
        .io_rdata(d15_io_rdata), .io_ack(d15_io_ack),
        .mem_en(d15_mem_en), .mem_we(d15_mem_we), .mem_addr(d15_mem_addr), .mem_wdata(d15_mem_wdata),
        .mem_rdata({4'hA, d15_mem_addr})
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic spurious(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: ack seen with nothing expected (cycle %0d)", nm, cyc);
    endtask

    // Monitors: every ack pops one expectation carrying requester, data and ack cycle.
    always @(negedge clk) if (d2_cpu_ack || d2_io_ack) begin
        if (sb2.size() == 0) spurious("d2_ack");
        else begin
            e2 = sb2.pop_front();
            chk("d2_ack_id", {30'd0, d2_cpu_ack, d2_io_ack}, e2.id ? 32'd1 : 32'd2);
            chk("d2_ack_cycle", cyc, e2.cyc);
            chk("d2_rdata", e2.id ? d2_io_rdata : d2_cpu_rdata, e2.data);
        end
    end

    always @(negedge clk) if (d1_ack || d1_io_ack) begin
        if (sb1.size() == 0) spurious("d1_ack");
        else begin
            e1 = sb1.pop_front();
            chk("d1_ack_id", {31'd0, d1_io_ack}, 32'(e1.id));
            chk("d1_ack_cycle", cyc, e1.cyc);
            chk("d1_rdata", d1_rdata, e1.data);
        end
    end

    always @(negedge clk) if (d15_ack || d15_io_ack) begin
        if (sb15.size() == 0) spurious("d15_ack");
        else begin
            e15 = sb15.pop_front();
            chk("d15_ack_id", {31'd0, d15_io_ack}, 32'(e15.id));
            chk("d15_ack_cycle", cyc, e15.cyc);
            chk("d15_rdata", d15_rdata, e15.data);
        end
    end

    initial begin
        int c0;
        int en1, en15, we1, we15;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", d2_mem_en, 0);
        chk("rst_mem_we", d2_mem_we, 0);
        chk("rst_acks", {d2_cpu_ack, d2_io_ack}, 0);
        chk("rst_mem_addr", d2_mem_addr, 0);
        chk("rst_cpu_rdata", d2_cpu_rdata, 0);
        @(posedge clk); #1 reset = 0;

        // CPU write interrupted by reset in its first ACCESS cycle
        @(posedge clk); #1;
        d2_cpu_req = 1; d2_cpu_we = 1; d2_cpu_addr = 12'h055; d2_cpu_wdata = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre_en", d2_mem_en, 1);
        chk("midrst_pre_we", d2_mem_we, 1);
        reset = 1;
        #1;
        chk("midrst_en", d2_mem_en, 0);
        chk("midrst_we", d2_mem_we, 0);
        chk("midrst_addr", d2_mem_addr, 0);
        chk("midrst_wdata", d2_mem_wdata, 0);
        chk("midrst_acks", {d2_cpu_ack, d2_io_ack}, 0);
        d2_cpu_req = 0; d2_cpu_we = 0; d2_cpu_wdata = 0;
        @(posedge clk); #1 reset = 0;
        repeat (6) @(negedge clk);
        chk("midrst_idle_en", d2_mem_en, 0);

        // CPU read of 0x02A returning BEEF
        @(posedge clk); #1;
        c0 = cyc;
        d2_cpu_req = 1; d2_cpu_addr = 12'h02A;
        sb2.push_back('{id: 1'b0, data: 16'hBEEF, cyc: c0 + 3});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rd_en_c%0d", k), d2_mem_en, (k == 1 || k == 2) ? 1 : 0);
            chk($sformatf("rd_we_c%0d", k), d2_mem_we, 0);
            chk($sformatf("rd_wait_c%0d", k), d2_cpu_wait, k < 3 ? 1 : 0);
            if (k == 1) chk("rd_addr", d2_mem_addr, 32'h02A);
            if (k == 3) d2_cpu_req = 0;
        end

        // IO write 0x100 <= 1234
        @(posedge clk); #1;
        c0 = cyc;
        d2_io_req = 1; d2_io_we = 1; d2_io_addr = 12'h100; d2_io_wdata = 16'h1234;
        sb2.push_back('{id: 1'b1, data: 16'h0000, cyc: c0 + 3});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("wr_en_c%0d", k), d2_mem_en, (k == 1 || k == 2) ? 1 : 0);
            chk($sformatf("wr_we_c%0d", k), d2_mem_we, k == 1 ? 1 : 0);
            if (k == 1) begin
                chk("wr_addr", d2_mem_addr, 32'h100);
                chk("wr_wdata", d2_mem_wdata, 32'h1234);
            end
            if (k == 3) begin
                d2_io_req = 0; d2_io_we = 0;
            end
        end

        // contention from reset release: CPU, IO, CPU, IO
        @(posedge clk); #1;
        reset = 1;
        d2_cpu_req = 1; d2_cpu_addr = 12'h200;
        d2_io_req = 1; d2_io_addr = 12'h300; d2_io_wdata = 0;
        @(negedge clk);
        chk("rst_clears_cpu_rdata", d2_cpu_rdata, 0);
        chk("rst_clears_io_rdata", d2_io_rdata, 0);
        @(posedge clk); #1 reset = 0;
        c0 = cyc;
        sb2.push_back('{id: 1'b0, data: 16'h1111, cyc: c0 + 3});
        sb2.push_back('{id: 1'b1, data: 16'h2222, cyc: c0 + 7});
        sb2.push_back('{id: 1'b0, data: 16'h1111, cyc: c0 + 11});
        sb2.push_back('{id: 1'b1, data: 16'h2222, cyc: c0 + 15});
        repeat (16) @(posedge clk);
        #1;
        d2_cpu_req = 0; d2_io_req = 0;

        // CPU holds req across ack for two consecutive reads
        @(posedge clk); #1;
        c0 = cyc;
        d2_cpu_req = 1; d2_cpu_addr = 12'h010;
        sb2.push_back('{id: 1'b0, data: 16'h0001, cyc: c0 + 3});
        sb2.push_back('{id: 1'b0, data: 16'h0002, cyc: c0 + 7});
        repeat (4) @(posedge clk);
        #1 d2_cpu_addr = 12'h011;
        repeat (4) @(posedge clk);
        #1 d2_cpu_req = 0;

        // latency extremes: MEM_LAT=1 and MEM_LAT=15 single reads
        @(posedge clk); #1;
        c0 = cyc;
        d1_req = 1; d1_addr = 12'h0AB;
        d15_req = 1; d15_addr = 12'h0CD;
        sb1.push_back('{id: 1'b0, data: 16'hA0AB, cyc: c0 + 2});
        sb15.push_back('{id: 1'b0, data: 16'hA0CD, cyc: c0 + 16});
        en1 = 0; en15 = 0; we1 = 0; we15 = 0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            en1 += int'(d1_mem_en);
            en15 += int'(d15_mem_en);
            we1 += int'(d1_mem_we);
            we15 += int'(d15_mem_we);
            if (k == 0) chk("d15_wait_c0", d15_wait, 1);
            if (k == 1) chk("d1_addr", d1_mem_addr, 32'h0AB);
            if (k == 2) begin
                chk("d1_wait_ack", d1_wait, 0);
                d1_req = 0;
            end
            if (k == 15) chk("d15_en_last", d15_mem_en, 1);
            if (k == 16) d15_req = 0;
        end
        chk("d1_en_cycles", en1, 1);
        chk("d15_en_cycles", en15, 15);
        chk("d1_we_cycles", we1, 0);
        chk("d15_we_cycles", we15, 0);
        chk("d1_io_rdata", d1_io_rdata, 0);
        chk("d15_io_rdata", d15_io_rdata, 0);
        chk("d1_mem_wdata", d1_mem_wdata, 0);
        chk("d15_mem_wdata", d15_mem_wdata, 0);
        chk("d15_mem_addr", d15_mem_addr, 32'h0CD);

        for (int i = 0; i < 50 && (sb2.size() + sb1.size() + sb15.size()) > 0; i++) @(negedge clk);
        chk("pending_acks", sb2.size() + sb1.size() + sb15.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
